// File: rtl/lane_align_pkg.sv
// Shared types and sizing helpers for the lane alignment training controller.
package lane_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DECIDE,
    ST_SLIP,
    ST_NEXT,
    ST_DONE
  } align_state_t;

  localparam logic PAT_RISE_DEF = 1'b1;
  localparam logic PAT_FALL_DEF = 1'b0;

  // Counter width able to index n distinct values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/align_window_counter.sv
// Evaluation window sample counter with a saturating mismatch counter.
module align_window_counter
  import lane_align_pkg::*;
#(
  parameter int unsigned CHECK_LEN = 64
) (
  input  logic dco_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic mismatch,
  output logic window_done,
  output logic err_zero
);

  localparam int unsigned CNT_W = cnt_w(CHECK_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHECK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHECK_LEN);

  logic [CNT_W-1:0] chk_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // window_done is pre-decoded so it is high during the final sample of the window
  always_ff @(posedge dco_clk) begin
    if (rst) begin
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      window_done <= 1'b0;
      err_zero    <= 1'b1;
    end else if (clear) begin
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      window_done <= (CHECK_LEN == 1);
      err_zero    <= 1'b1;
    end else if (enable) begin
      chk_cnt_q   <= chk_cnt_q + CNT_W'(1);
      window_done <= ((chk_cnt_q + CNT_W'(1)) == CNT_LAST);
      if (mismatch && (err_cnt_q != CNT_FULL)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      err_zero    <= err_zero && !mismatch;
    end
  end

endmodule

// File: rtl/lane_align_ctrl.sv
// Per-lane bitslip training controller: checks each lane against a static
// pattern and slips it until it matches or its retries run out.
module lane_align_ctrl
  import lane_align_pkg::*;
#(
  parameter int unsigned LANES     = 8,
  parameter int unsigned CHECK_LEN = 64,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned MAX_SLIPS = 2,
  parameter logic        PAT_RISE  = PAT_RISE_DEF,
  parameter logic        PAT_FALL  = PAT_FALL_DEF
) (
  input  logic             dco_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] lane_rise,
  input  logic [LANES-1:0] lane_fall,
  output logic [LANES-1:0] bitslip_pulse,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] locked,
  output logic [LANES-1:0] fail
);

  localparam int unsigned IDX_W  = cnt_w(LANES);
  localparam int unsigned SLIP_W = cnt_w(MAX_SLIPS + 1);
  localparam int unsigned WAIT_W = cnt_w(SETTLE);

  localparam logic [IDX_W-1:0]  LANE_LAST   = IDX_W'(LANES - 1);
  localparam logic [SLIP_W-1:0] SLIP_LIMIT  = SLIP_W'(MAX_SLIPS);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE - 1);

  // Slip stage needs pulse->offset plus offset->output register latency
  if (SETTLE < 3) begin : g_settle_chk
    $error("lane_align_ctrl: SETTLE must be at least 3");
  end

  align_state_t      state_q, state_d;
  logic [IDX_W-1:0]  lane_idx_q, lane_idx_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LANES-1:0]  locked_d, fail_d, bitslip_d;
  logic              win_clear, win_enable, window_done, err_zero;
  logic              mismatch_c;

  assign mismatch_c = (lane_rise[lane_idx_q] != PAT_RISE) ||
                      (lane_fall[lane_idx_q] != PAT_FALL);

  align_window_counter #(
    .CHECK_LEN (CHECK_LEN)
  ) u_window (
    .dco_clk     (dco_clk),
    .rst         (rst),
    .clear       (win_clear),
    .enable      (win_enable),
    .mismatch    (mismatch_c),
    .window_done (window_done),
    .err_zero    (err_zero)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    slip_cnt_d = slip_cnt_q;
    wait_cnt_d = wait_cnt_q;
    locked_d   = locked;
    fail_d     = fail;
    win_clear  = 1'b0;
    win_enable = 1'b0;
    bitslip_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lane_idx_d = '0;
          slip_cnt_d = '0;
          locked_d   = '0;
          fail_d     = '0;
          wait_cnt_d = SETTLE_LAST;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (wait_cnt_q == '0) begin
          win_clear = 1'b1;
          state_d   = ST_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        win_enable = 1'b1;
        if (window_done) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (err_zero) begin
          locked_d[lane_idx_q] = 1'b1;
          state_d              = ST_NEXT;
        end else if (slip_cnt_q == SLIP_LIMIT) begin
          fail_d[lane_idx_q] = 1'b1;
          state_d            = ST_NEXT;
        end else begin
          state_d = ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        wait_cnt_d = SETTLE_LAST;
        state_d    = ST_SETTLE;
      end
      ST_NEXT: begin
        if (lane_idx_q == LANE_LAST) begin
          state_d = ST_DONE;
        end else begin
          lane_idx_d = lane_idx_q + IDX_W'(1);
          slip_cnt_d = '0;
          wait_cnt_d = SETTLE_LAST;
          state_d    = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pulse is registered so it is visible exactly while the FSM sits in SLIP
    if (state_d == ST_SLIP) bitslip_d = LANES'(1) << lane_idx_q;
  end

  always_ff @(posedge dco_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lane_idx_q    <= '0;
      slip_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      locked        <= '0;
      fail          <= '0;
      bitslip_pulse <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_idx_q    <= lane_idx_d;
      slip_cnt_q    <= slip_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      locked        <= locked_d;
      fail          <= fail_d;
      bitslip_pulse <= bitslip_d;
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
    end
  end

endmodule

// File: doc/lane_align_ctrl.md
# lane_align_ctrl

Training controller for the per-lane half-bit slip stage of the ADC frontend. On `start`, it visits lanes one at a time. For each lane it:
- compares the slip stage's registered rise/fall outputs against a static training pattern over a fixed window;
- issues `bitslip_pulse` until the lane matches or runs out of retries;
- reports per-lane lock or failure.

One shared window counter and one shared error counter serve all lanes.

## Interface
- `LANES`, 8: number of lanes, ≥1.
- `CHECK_LEN`, 64: samples per evaluation window, ≥1.
- `SETTLE`, 4: wait cycles after a slip or lane change before sampling; ≥3, checked by elaboration assertion.
- `MAX_SLIPS`, 2: slip attempts per lane before failure.
- `PAT_RISE`, 1'b1: expected rise-phase bit during training.
- `PAT_FALL`, 1'b0: expected fall-phase bit during training.
- `dco_clk` in 1: single clock, same domain as the slip stage posedge logic.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a full training pass; sampled only in IDLE.
- `lane_rise` in LANES: corrected rise outputs of the slip stage.
- `lane_fall` in LANES: corrected fall outputs of the slip stage.
- `bitslip_pulse` out LANES: one-cycle toggle request to the slip stage; at most one bit high at a time.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of the pass.
- `locked` out LANES: lane matched the pattern; held until the next accepted `start`.
- `fail` out LANES: lane exhausted its slips; held until the next accepted `start`.

## Operation
States: IDLE, SETTLE, CHECK, DECIDE, SLIP, NEXT, DONE.
- **IDLE:** on `start=1`:
  - `lane_idx←0`, `slip_cnt←0`, `locked←0`, `fail←0`, `wait_cnt←SETTLE-1`;
  - go to SETTLE.
- **SETTLE:** decrement `wait_cnt`. At 0: `chk_cnt←0`, `err_cnt←0`, go to CHECK.
- **CHECK:**
  - A sample is a mismatch if `lane_rise[lane_idx]!=PAT_RISE` or `lane_fall[lane_idx]!=PAT_FALL`.
  - Each mismatch increments `err_cnt`, saturating at CHECK_LEN.
  - After CHECK_LEN samples, go to DECIDE.
- **DECIDE:**
  - If `err_cnt==0`: `locked[lane_idx]←1`, go to NEXT.
  - Else if `slip_cnt==MAX_SLIPS`: `fail[lane_idx]←1`, go to NEXT.
  - Else go to SLIP.
- **SLIP:** `bitslip_pulse[lane_idx]=1` for this cycle only; `slip_cnt++`; `wait_cnt←SETTLE-1`; go to SETTLE.
- **NEXT:**
  - If `lane_idx==LANES-1`, go to DONE.
  - Else `lane_idx++`, `slip_cnt←0`, `wait_cnt←SETTLE-1`, go to SETTLE.
- **DONE:** `done=1` for this cycle; go to IDLE.

Widths and invariants:
- `lane_idx`: `max(1,$clog2(LANES))`.
- `chk_cnt` and `err_cnt`: `$clog2(CHECK_LEN+1)`.
- `slip_cnt`: `$clog2(MAX_SLIPS+1)`.
- `locked & fail` is always 0.
- The block does not reset the slip stage's offset state. Its own `rst` clears only the controller.

## Timing
- Reset values: state IDLE; `bitslip_pulse=0`, `busy=0`, `done=0`, `locked=0`, `fail=0`; all counters 0.
- Reset asserted mid-pass aborts the pass on the next edge. No pulse is emitted in or after that cycle.
- All outputs are registered.
- `start` sampled at edge 0 gives SETTLE in cycle 1.
- Cycles per lane: `SETTLE+CHECK_LEN+2` for a lane with no slips.
  - Each slip adds `SETTLE+CHECK_LEN+2`.
- With defaults and all lanes clean, `done` is high in cycle 561.
- `start` while `busy=1` is ignored. `start` held high through DONE retriggers from IDLE one cycle after `done`.
- SETTLE≥3 covers the slip-stage latency: pulse → offset register, then offset → `out_rise`/`out_fall` registers (including the negedge path).

## Structure
- Package `lane_align_pkg`:
  - `align_state_t` enum;
  - default `PAT_RISE`/`PAT_FALL` constants;
  - `clog2` helper localparams.
- Sub-module `align_window_counter`:
  - window sample counter plus saturating error counter;
  - inputs: clear, enable, mismatch;
  - outputs: `window_done`, `err_zero`.
- The FSM, lane index, slip counter and output registers live in the top module.

## Test plan
- All lanes driven rise=1/fall=0, `start` pulse → no `bitslip_pulse` ever; `locked=8'hFF`, `fail=0`; `done` in cycle 561.
- Lane 3 starts inverted (bench slip-stage model toggles on pulse) → exactly one pulse on bit 3; `locked[3]=1`; `done` in cycle 631.
- Lane 5 random data, all others clean → exactly 2 pulses on bit 5; `fail=8'h20`, `locked=8'hDF`.
- Lane 0 with a single mismatch injected in the last CHECK sample → one slip issued. With the clean pattern after the slip → `locked[0]=1`.
- `rst` asserted in CHECK of lane 2 → next edge all outputs 0, state IDLE. A new `start` completes normally.
- `start` re-pulsed while `busy=1` → ignored; exactly one `done` pulse per accepted start.
